// File: rtl/byte_rom_rd_pipe.sv
// Byte-addressed ROM with a valid/ready request port and a credited response FIFO.
// Returns WORD_BYTES little-endian bytes, or err=1 with zero data on a faulted access.
module byte_rom_rd_pipe #(
    parameter int DEPTH_BYTES = 1024,
    parameter int WORD_BYTES  = 4,
    parameter int ADDR_W      = 32,
    parameter int LATENCY     = 1,
    parameter int ALIGN_CHECK = 0,
    parameter int INIT_RAMP   = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [ADDR_W-1:0]       req_addr,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [8*WORD_BYTES-1:0] rsp_data,
    output logic                    rsp_err
);

    localparam int DW        = 8 * WORD_BYTES;
    localparam int AW        = $clog2(DEPTH_BYTES);
    localparam int RSP_DEPTH = LATENCY + 1;
    localparam int PW        = $clog2(RSP_DEPTH);
    localparam int CW        = $clog2(RSP_DEPTH + 1);

    localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(DEPTH_BYTES - WORD_BYTES);
    localparam logic [ADDR_W-1:0] AMASK = ADDR_W'(WORD_BYTES - 1);
    localparam logic [CW-1:0]     FULL  = CW'(RSP_DEPTH);
    localparam logic [PW-1:0]     PLAST = PW'(RSP_DEPTH - 1);

    logic [7:0] rom [DEPTH_BYTES];

    for (genvar i = 0; i < DEPTH_BYTES; i++) begin : g_rom
        assign rom[i] = (INIT_RAMP != 0) ? 8'(i) : 8'h00;
    end

    logic          acc;
    logic          pop;
    logic          acc_e;
    logic [DW-1:0] acc_d;
    logic [AW-1:0] lo;
    logic          wr_v;
    logic          wr_e;
    logic [DW-1:0] wr_d;

    assign acc = req_valid & req_ready;
    assign pop = rsp_valid & rsp_ready;
    assign lo  = req_addr[AW-1:0];

    // Fault check and little-endian byte gather for the request being accepted.
    always_comb begin
        acc_e = (req_addr > LAST)
              | ((ALIGN_CHECK != 0) && ((req_addr & AMASK) != '0));
        acc_d = '0;
        if (!acc_e) begin
            for (int k = 0; k < WORD_BYTES; k++) begin
                acc_d[8*k +: 8] = rom[lo + AW'(k)];
            end
        end
    end

    if (LATENCY == 1) begin : g_lat1
        assign wr_v = acc;
        assign wr_d = acc_d;
        assign wr_e = acc_e;
    end else begin : g_latn
        logic [LATENCY-2:0] pv;
        logic [LATENCY-2:0] pe;
        logic [DW-1:0]      pd [LATENCY-1];

        // Delay line between accept and the response buffer write.
        always_ff @(posedge clk) begin
            if (rst) begin
                pv <= '0;
                pe <= '0;
                for (int i = 0; i < LATENCY - 1; i++) pd[i] <= '0;
            end else begin
                pv[0] <= acc;
                pe[0] <= acc_e;
                pd[0] <= acc_d;
                for (int i = 1; i < LATENCY - 1; i++) begin
                    pv[i] <= pv[i-1];
                    pe[i] <= pe[i-1];
                    pd[i] <= pd[i-1];
                end
            end
        end

        assign wr_v = pv[LATENCY-2];
        assign wr_d = pd[LATENCY-2];
        assign wr_e = pe[LATENCY-2];
    end

    logic [DW-1:0]        bd [RSP_DEPTH];
    logic [RSP_DEPTH-1:0] be;
    logic [PW-1:0]        wp;
    logic [PW-1:0]        rp;
    logic [CW-1:0]        cnt;
    logic [CW-1:0]        inflight;
    logic [DW-1:0]        last_d;
    logic                 last_e;

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (p == PLAST) ? '0 : p + 1'b1;
    endfunction

    // Response FIFO; the last popped entry is kept so outputs hold when empty.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < RSP_DEPTH; i++) bd[i] <= '0;
            be     <= '0;
            wp     <= '0;
            rp     <= '0;
            cnt    <= '0;
            last_d <= '0;
            last_e <= 1'b0;
        end else begin
            if (wr_v) begin
                bd[wp] <= wr_d;
                be[wp] <= wr_e;
                wp     <= nxt(wp);
            end
            if (pop) begin
                rp     <= nxt(rp);
                last_d <= bd[rp];
                last_e <= be[rp];
            end
            if (wr_v && !pop) cnt <= cnt + 1'b1;
            else if (!wr_v && pop) cnt <= cnt - 1'b1;
        end
    end

    // Credit counter covering both the delay line and the buffer.
    always_ff @(posedge clk) begin
        if (rst) begin
            inflight <= '0;
        end else if (acc && !pop) begin
            inflight <= inflight + 1'b1;
        end else if (!acc && pop) begin
            inflight <= inflight - 1'b1;
        end
    end

    assign req_ready = !rst && (inflight < FULL);
    assign rsp_valid = (cnt != '0);
    assign rsp_data  = rsp_valid ? bd[rp] : last_d;
    assign rsp_err   = rsp_valid ? be[rp] : last_e;

endmodule

// File: tb/tb_byte_rom_rd_pipe.sv
// Randomized bench for byte_rom_rd_pipe: two configurations checked
// against a queue-based reference of ROM reads, latency and credits.
module tb_byte_rom_rd_pipe;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        rsp_ready = 1'b0;
    logic [31:0] req_addr = '0;

    logic        rdy0, v0, e0;
    logic        rdy1, v1, e1;
    logic [31:0] d0, d1;

    always #5 clk = ~clk;

    byte_rom_rd_pipe #(
        .DEPTH_BYTES(1024), .WORD_BYTES(4), .ADDR_W(32),
        .LATENCY(2), .ALIGN_CHECK(0), .INIT_RAMP(1)
    ) u0 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(rdy0), .req_addr(req_addr),
        .rsp_valid(v0), .rsp_ready(rsp_ready),
        .rsp_data(d0), .rsp_err(e0)
    );

    byte_rom_rd_pipe #(
        .DEPTH_BYTES(1024), .WORD_BYTES(4), .ADDR_W(32),
        .LATENCY(1), .ALIGN_CHECK(1), .INIT_RAMP(1)
    ) u1 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(rdy1), .req_addr(req_addr),
        .rsp_valid(v1), .rsp_ready(rsp_ready),
        .rsp_data(d1), .rsp_err(e1)
    );

    typedef struct {
        logic [31:0] d;
        bit          e;
        int          t;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    int   cyc   = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
        end
    endtask

    // Byte i holds i mod 256; out of range or (when checked) unaligned faults.
    function automatic exp_t ref_rd(input logic [31:0] a, input bit align,
                                    input int t);
        exp_t r;
        r.t = t;
        r.e = (a > 32'd1020) || (align && (a % 4 != 0));
        r.d = '0;
        if (!r.e) begin
            for (int k = 0; k < 4; k++) r.d[8*k +: 8] = 8'((a + k) % 256);
        end
        return r;
    endfunction

    function automatic bit vis0();
        return q0.size() > 0 && q0[0].t <= cyc;
    endfunction

    function automatic bit vis1();
        return q1.size() > 0 && q1[0].t <= cyc;
    endfunction

    task automatic check_all();
        chk("rdy0", rdy0, !rst && q0.size() < 3);
        chk("vld0", v0, vis0());
        if (vis0()) begin
            chk("dat0", d0, q0[0].d);
            chk("err0", e0, q0[0].e);
        end
        chk("rdy1", rdy1, !rst && q1.size() < 2);
        chk("vld1", v1, vis1());
        if (vis1()) begin
            chk("dat1", d1, q1[0].d);
            chk("err1", e1, q1[0].e);
        end
    endtask

    // Drive one cycle, predict the coming edge, then check after it.
    task automatic step(input bit v, input logic [31:0] a,
                        input bit rr, input bit r);
        bit ok0, ok1, p0, p1;
        rst       = r;
        req_valid = v;
        req_addr  = a;
        rsp_ready = rr;
        ok0 = !r && q0.size() < 3;
        ok1 = !r && q1.size() < 2;
        p0  = vis0() && rr;
        p1  = vis1() && rr;
        if (r) begin
            q0.delete();
            q1.delete();
        end else begin
            if (p0) void'(q0.pop_front());
            if (p1) void'(q1.pop_front());
            if (v && ok0) q0.push_back(ref_rd(a, 1'b0, cyc + 2));
            if (v && ok1) q1.push_back(ref_rd(a, 1'b1, cyc + 1));
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
        check_all();
    endtask

    initial begin
        step(0, 0, 0, 1);
        step(0, 0, 0, 1);
        chk("rst_d0", d0, 0);
        chk("rst_e0", e0, 0);
        chk("rst_d1", d1, 0);
        chk("rst_e1", e1, 0);

        step(1, 32'h0, 1, 0);
        step(0, 0, 1, 0);
        step(0, 0, 1, 0);
        step(1, 32'h5, 1, 0);
        step(0, 0, 1, 0);
        step(0, 0, 1, 0);
        step(1, 32'd1020, 1, 0);
        step(1, 32'd1021, 1, 0);
        step(1, 32'hFFFF_FFFE, 1, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 1, 0);

        for (int i = 0; i < 5; i++) step(1, 4 * i, 0, 0);
        for (int i = 0; i < 6; i++) step(1, 4 * (i + 3), 1, 0);
        for (int i = 0; i < 4; i++) step(0, 0, 1, 0);

        for (int i = 0; i < 16; i++) step(1, 4 * i, 1, 0);
        for (int i = 0; i < 4; i++) step(0, 0, 1, 0);

        step(1, 32'd8, 0, 0);
        step(1, 32'd12, 0, 0);
        step(0, 0, 0, 1);
        for (int i = 0; i < 4; i++) step(0, 0, 1, 0);

        for (int i = 0; i < 400; i++) begin
            logic [31:0] a;
            case ($urandom_range(0, 3))
                0: a = 4 * $urandom_range(0, 255);
                1: a = $urandom_range(0, 1023);
                2: a = $urandom_range(1012, 1031);
                default: a = $urandom;
            endcase
            step($urandom_range(0, 3) != 0, a,
                 $urandom_range(0, 3) != 0, $urandom_range(0, 99) == 0);
        end
        for (int i = 0; i < 6; i++) step(0, 0, 1, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
